// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Drives a 4-digit common-anode 7-segment display. A 14-bit binary value is
//   accepted over a valid/ready handshake and converted to BCD one bit per
//   clock (shift-and-add-3). The display digits are time-multiplexed with a
//   per-digit dwell, and each dwell opens with a blank window to prevent
//   ghosting. Values above 9999 are clamped to 9999 and flagged on ovf_o.
//
//   Optional: define SEVEN_SEG_LEADING_ZERO_BLANK_EN to blank the leading zero
//   digits. The units digit is always shown.
//
// Parameters
//   REFRESH_CYCLES  cycles each digit stays selected (>= 2)
//   BLANK_CYCLES    cycles with all anodes off at the start of each dwell
//                   (0 <= BLANK_CYCLES < REFRESH_CYCLES)
//
// Ports
//   clk_i          system clock, posedge
//   reset_i        synchronous, active-high reset
//   upd_valid_i    new value offered
//   upd_value_i    binary value to display (14 bits)
//   upd_ready_o    block can accept a value
//   ovf_o          last committed value exceeded 9999
//   anode_n_o      digit select, active-low, bit 0 = units
//   seg_n_o        segments {g,f,e,d,c,b,a}, active-low
//   dp_n_o         decimal point, active-low, tied off (1)
module seven_seg_scanner #(
    parameter int REFRESH_CYCLES = 100_000,
    parameter int BLANK_CYCLES   = 1_000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        upd_valid_i,
    input  logic [13:0] upd_value_i,
    output logic        upd_ready_o,
    output logic        ovf_o,
    output logic [3:0]  anode_n_o,
    output logic [6:0]  seg_n_o,
    output logic        dp_n_o
);

    localparam int DW = $clog2(REFRESH_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_COMMIT} state_t;

    state_t           state_q, state_d;
    logic [13:0]      val_q;
    logic             ovf_pend_q;
    logic             ovf_q;
    logic [3:0]       it_q;
    // {bcd[15:0], bin[13:0]}: BCD grows in from the top as binary shifts out
    logic [29:0]      sh_q, sh_d;
    logic [3:0][3:0]  digit_q;

    logic [DW-1:0]    dwell_q;
    logic [1:0]       idx_q;
    logic [3:0]       anode_n_q;
    logic [6:0]       seg_n_q;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b0111111;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1101111;
            default: decode = 7'b0000000;
        endcase
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (upd_valid_i) state_d = S_CONVERT;
            S_CONVERT: if (it_q == 4'd14) state_d = S_COMMIT;
            S_COMMIT:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        upd_ready_o = (state_q == S_IDLE);
    end

    // One double-dabble iteration: correct nibbles >= 5, then shift left.
    always_comb begin
        logic [29:0] adj;
        adj = sh_q;
        for (int k = 0; k < 4; k++) begin
            if (adj[14+4*k +: 4] >= 4'd5) adj[14+4*k +: 4] = adj[14+4*k +: 4] + 4'd3;
        end
        sh_d = {adj[28:0], 1'b0};
    end

    // Conversion datapath. The first CONVERT cycle (it_q == 0) primes the
    // shift register from the clamped capture; iterations run at it_q 1..14,
    // which puts the commit 16 edges after the handshake.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            val_q      <= '0;
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            it_q       <= '0;
            sh_q       <= '0;
            digit_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (upd_valid_i) begin
                    val_q      <= (upd_value_i > 14'd9999) ? 14'd9999 : upd_value_i;
                    ovf_pend_q <= (upd_value_i > 14'd9999);
                    it_q       <= '0;
                end
                S_CONVERT: begin
                    it_q <= it_q + 4'd1;
                    if (it_q == 4'd0) sh_q <= {16'd0, val_q};
                    else              sh_q <= sh_d;
                end
                S_COMMIT: begin
                    digit_q <= sh_q[29:14];
                    ovf_q   <= ovf_pend_q;
                end
                default: ;
            endcase
        end
    end

    // ---------------- Scan: free-running, never touched by the FSM ----------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            dwell_q <= '0;
            idx_q   <= '0;
        end else if (dwell_q == DW'(REFRESH_CYCLES - 1)) begin
            dwell_q <= '0;
            idx_q   <= idx_q + 2'd1;
        end else begin
            dwell_q <= dwell_q + DW'(1);
        end
    end

    logic blank_win;
    logic lead_blank;
    assign blank_win = (int'(dwell_q) < BLANK_CYCLES);

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // A digit is blank when it and every digit above it are zero.
    always_comb begin
        case (idx_q)
            2'd3:    lead_blank = (digit_q[3] == 4'd0);
            2'd2:    lead_blank = (digit_q[3:2] == 8'd0);
            2'd1:    lead_blank = (digit_q[3:1] == 12'd0);
            default: lead_blank = 1'b0;
        endcase
    end
`else
    assign lead_blank = 1'b0;
`endif

    // Registered display outputs, one cycle behind the scan counters.
    always_ff @(posedge clk_i) begin
        if (reset_i || blank_win) begin
            anode_n_q <= 4'b1111;
            seg_n_q   <= 7'b1111111;
        end else begin
            anode_n_q <= ~(4'b0001 << idx_q);
            seg_n_q   <= lead_blank ? 7'b1111111 : ~decode(digit_q[idx_q]);
        end
    end

    assign anode_n_o = anode_n_q;
    assign seg_n_o   = seg_n_q;
    assign ovf_o     = ovf_q;
    assign dp_n_o    = 1'b1;

endmodule
